// File: rtl/corr_frame_sequencer.sv
// corr_frame_sequencer: snapshots a bank of correlator accumulators into shadow
// registers and offers them one word at a time to the hex-ASCII word transmitter,
// stepping to the next word on each rising edge of the transmitter's done level.
//
// Optional build macro: CORR_FRAME_HEADER_EN
//   defined   -> each frame is prefixed with a header word {8'hA5, frame_cnt}
//   undefined -> frame is exactly CHANNELS words (frame_cnt still kept internally)
module corr_frame_sequencer #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned RESOLUTION = 32,
    parameter int unsigned IDX_BITS   = $clog2(CHANNELS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           snap,
    input  logic [CHANNELS*RESOLUTION-1:0] ch_data,
    input  logic                           tx_done,
    output logic [RESOLUTION-1:0]          tx_data,
    output logic                           tx_enable,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned CNT_W = RESOLUTION - 8;

`ifdef CORR_FRAME_HEADER_EN
    localparam int unsigned LAST = CHANNELS;
`else
    localparam int unsigned LAST = CHANNELS - 1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
    } state_e;

    // ------------------------------------------------------------------
    // done synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       done_prev_q, done_prev_d;
    logic       adv_q, adv_d;
    // Counts the first cycles after reset; edges seen before the synchronizer
    // holds a real sample of tx_done are artefacts of the reset values.
    logic [1:0] settle_q, settle_d;

    // Next-state for the synchronizer, edge detector and settle counter
    always_comb begin
        sync1_d     = tx_done;
        sync2_d     = sync1_q;
        done_prev_d = sync2_q;
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        adv_d       = sync2_q & ~done_prev_q & (settle_q == 2'd3);
    end

    // Synchronizer / edge detector registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            done_prev_q <= 1'b0;
            adv_q       <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            done_prev_q <= done_prev_d;
            adv_q       <= adv_d;
            settle_q    <= settle_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_e                         state_q, state_d;
    logic [IDX_BITS-1:0]            idx_q, idx_d;
    logic [CHANNELS*RESOLUTION-1:0] shadow_q, shadow_d;
    logic [RESOLUTION-1:0]          tx_data_q, tx_data_d;
    logic                           tx_enable_q, tx_enable_d;
    logic                           busy_q, busy_d;
    logic                           overrun_q, overrun_d;
    logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;

    logic [IDX_BITS-1:0]            nxt_idx;
    logic [IDX_BITS-1:0]            ch_sel;
    int unsigned                    ch_base;
    logic [RESOLUTION-1:0]          first_word;
    logic [RESOLUTION-1:0]          next_word;

    // Word selection: first word of a frame and the word following idx_q
    always_comb begin
        nxt_idx = idx_q + 1'b1;
`ifdef CORR_FRAME_HEADER_EN
        // Header occupies index 0, so channel k sits at index k+1.
        first_word = {8'hA5, frame_cnt_q};
        ch_sel     = idx_q;
`else
        // First word comes straight from the bank being captured this cycle.
        first_word = ch_data[RESOLUTION-1:0];
        ch_sel     = nxt_idx;
`endif
        ch_base   = 32'(ch_sel) * RESOLUTION;
        next_word = shadow_q[ch_base +: RESOLUTION];
    end

    // Next-state and output logic for the sequencer FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = tx_enable_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (snap) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                shadow_d    = ch_data;
                idx_d       = '0;
                tx_data_d   = first_word;
                tx_enable_d = 1'b1;
                busy_d      = 1'b1;
                state_d     = StWait;
                // A frame is already committed; a further request is lost.
                if (snap) begin
                    overrun_d = 1'b1;
                end
            end
            StWait: begin
                // busy is still high on the cycle of the final adv, so a
                // coincident snap is dropped as well.
                if (snap) begin
                    overrun_d = 1'b1;
                end
                if (adv_q) begin
                    if (idx_q == IDX_BITS'(LAST)) begin
                        state_d     = StIdle;
                        tx_enable_d = 1'b0;
                        busy_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = next_word;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            shadow_q    <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Directed bench for corr_frame_sequencer (CHANNELS=4, RESOLUTION=32).
// Expected words are built from the stimulus banks; with CORR_FRAME_HEADER_EN the
// bench prefixes each frame with {8'hA5, frames completed since reset}.
module tb_corr_frame_sequencer;

    localparam int unsigned CH  = 4;
    localparam int unsigned RES = 32;

    logic              clk;
    logic              rst;
    logic              snap;
    logic [CH*RES-1:0] ch_data;
    logic              tx_done;
    logic [RES-1:0]    tx_data;
    logic              tx_enable;
    logic              busy;
    logic              overrun;

    int unsigned vecs;
    int unsigned errs;
    int unsigned fcnt;
    logic [31:0] exp_w[$];

    corr_frame_sequencer #(
        .CHANNELS  (CH),
        .RESOLUTION(RES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .snap     (snap),
        .ch_data  (ch_data),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .tx_enable(tx_enable),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [CH*RES-1:0] bank);
        exp_w.delete();
`ifdef CORR_FRAME_HEADER_EN
        exp_w.push_back({8'hA5, 24'(fcnt)});
`endif
        for (int k = 0; k < int'(CH); k++) begin
            exp_w.push_back(bank[k*RES +: RES]);
        end
    endtask

    // One done pulse: checks the 4-edge latency and the word/enable afterwards.
    task automatic pulse(input string tag, input logic [31:0] exp_prev,
                         input logic [31:0] exp_data, input logic exp_en,
                         input logic snap_at_adv);
        tx_done = 1'b1;
        repeat (3) tick();
        chk({tag, "_lat"}, tx_data, exp_prev);
        if (snap_at_adv) snap = 1'b1;
        tick();
        snap = 1'b0;
        chk(tag, tx_data, exp_data);
        chk({tag, "_en"}, {31'd0, tx_enable}, {31'd0, exp_en});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_en});
        tx_done = 1'b0;
        repeat (4) tick();
    endtask

    // Steps through words first..upto (not the frame end).
    task automatic run_words(input string tag, input int first, input int upto);
        for (int i = first; i <= upto; i++) begin
            pulse($sformatf("%s_w%0d", tag, i), exp_w[i-1], exp_w[i], 1'b1, 1'b0);
        end
    endtask

    task automatic finish_frame(input string tag, input logic snap_at_adv);
        int n;
        n = exp_w.size();
        pulse({tag, "_end"}, exp_w[n-1], exp_w[n-1], 1'b0, snap_at_adv);
        fcnt++;
    endtask

    task automatic start_frame(input string tag);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        chk({tag, "_w0"}, tx_data, exp_w[0]);
        chk({tag, "_en0"}, {31'd0, tx_enable}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        logic [CH*RES-1:0] bank_a;
        logic [CH*RES-1:0] bank_b;
        logic [CH*RES-1:0] bank_c;
        logic [CH*RES-1:0] bank_d;
        int last;

        bank_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bank_b = {32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0};
        bank_c = {32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1, 32'h90909090};
        bank_d = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
        vecs = 0;
        errs = 0;
        fcnt = 0;
        last = int'(CH) - 1;
`ifdef CORR_FRAME_HEADER_EN
        last = int'(CH);
`endif

        // Reset held 3 cycles with done high
        rst     = 1'b1;
        snap    = 1'b0;
        tx_done = 1'b1;
        ch_data = bank_a;
        repeat (3) tick();
        chk("rst_data", tx_data, 32'd0);
        chk("rst_en", {31'd0, tx_enable}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // Frame A: snap right after reset with done still high; no spurious advance
        build_frame(bank_a);
        start_frame("a");
        repeat (4) tick();
        chk("a_no_spurious", tx_data, exp_w[0]);
        // Capture isolation: bank changes after capture must not leak out
        ch_data = {CH{32'hFFFFFFFF}};
        tx_done = 1'b0;
        repeat (4) tick();
        run_words("a", 1, last);
        finish_frame("a", 1'b0);
        chk("a_ovr", {31'd0, overrun}, 32'd0);

        // Frame B: snap coincident with the final advance is dropped
        ch_data = bank_b;
        build_frame(bank_b);
        start_frame("b");
        run_words("b", 1, last);
        finish_frame("b", 1'b1);
        chk("b_ovr", {31'd0, overrun}, 32'd1);
        repeat (6) tick();
        chk("b_no_restart_en", {31'd0, tx_enable}, 32'd0);
        chk("b_no_restart_busy", {31'd0, busy}, 32'd0);
        chk("b_hold_data", tx_data, exp_w[last]);

        // Reset clears overrun and frame count
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        fcnt = 0;
        chk("r2_ovr", {31'd0, overrun}, 32'd0);
        chk("r2_data", tx_data, 32'd0);

        // Frame C: snap during word 1, then reset mid-frame at idx 2
        ch_data = bank_c;
        build_frame(bank_c);
        start_frame("c");
        run_words("c", 1, 1);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        chk("c_ovr", {31'd0, overrun}, 32'd1);
        chk("c_hold_w1", tx_data, exp_w[1]);
        run_words("c", 2, 2);
        rst = 1'b1;
        tick();
        chk("c_abort_en", {31'd0, tx_enable}, 32'd0);
        chk("c_abort_data", tx_data, 32'd0);
        chk("c_abort_busy", {31'd0, busy}, 32'd0);
        chk("c_abort_ovr", {31'd0, overrun}, 32'd0);
        rst  = 1'b0;
        fcnt = 0;
        tick();

        // Frame D: fresh snap restarts at word 0 and runs to completion
        ch_data = bank_d;
        build_frame(bank_d);
        start_frame("d");
        run_words("d", 1, last);
        finish_frame("d", 1'b0);
        chk("d_ovr", {31'd0, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
